// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out word assembler with a one-deep
// valid/ready output buffer and a sticky overrun flag.
// Optional feature macro PARITY_CHECK_EN: each frame carries a trailing
// even-parity bit and a parity_err flag travels with every buffered word.

module sipo_deserializer #(
  parameter int N         = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   ser_in,
  input  logic                   ser_valid,
  output logic [N-1:0]           word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   overrun,
`ifdef PARITY_CHECK_EN
  output logic                   parity_err,
`endif
  output logic [$clog2(N+1)-1:0] bit_cnt
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] DATA_BITS = CW'(N);
`endif

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   word_q, word_d;
  logic           ovr_q, ovr_d;
  logic [N-1:0]   shifted;
  logic [N-1:0]   new_word;
  logic           complete;
`ifdef PARITY_CHECK_EN
  logic           par_acc_q, par_acc_d;
  logic           perr_q, perr_d;
  logic           new_perr;
`endif

  // Shift path: accept a bit on every qualified cycle and spot the frame's final bit
  always_comb begin
    shifted  = MSB_FIRST ? {shift_q[N-2:0], ser_in} : {ser_in, shift_q[N-1:1]};
    complete = ser_valid && (cnt_q == LAST);
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef PARITY_CHECK_EN
    par_acc_d = par_acc_q;
    new_word  = shift_q;
    new_perr  = par_acc_q ^ ser_in;
    if (ser_valid) begin
      cnt_d = complete ? '0 : cnt_q + CW'(1);
      if (cnt_q < DATA_BITS) begin
        shift_d   = shifted;
        par_acc_d = par_acc_q ^ ser_in;
      end
      if (complete) begin
        par_acc_d = 1'b0;
      end
    end
`else
    new_word = shifted;
    if (ser_valid) begin
      cnt_d   = complete ? '0 : cnt_q + CW'(1);
      shift_d = shifted;
    end
`endif
  end

  // Output buffer: EMPTY/FULL handshake; a word arriving while FULL and not drained is dropped
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ovr_d   = ovr_q;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          word_d  = new_word;
`ifdef PARITY_CHECK_EN
          perr_d  = new_perr;
`endif
        end
      end
      FULL: begin
        if (complete) begin
          if (word_ready) begin
            word_d = new_word;
`ifdef PARITY_CHECK_EN
            perr_d = new_perr;
`endif
          end else begin
            ovr_d = 1'b1;
          end
        end else if (word_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers; clear wins over everything, dropping any partial word
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= EMPTY;
      shift_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      ovr_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      ovr_q     <= ovr_d;
`ifdef PARITY_CHECK_EN
      par_acc_q <= par_acc_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == FULL);
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer: two instances (MSB-first and LSB-first)
// share one serial stream and are compared every cycle against a queue-based
// reference model, with directed scenarios followed by random traffic.

module tb_sipo_deserializer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
`ifdef PARITY_CHECK_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          serIn = 1'b0;
  logic          serValid = 1'b0;
  logic          wordReady = 1'b0;
  logic [N-1:0]  wordOutM, wordOutL;
  logic          wordValidM, wordValidL;
  logic          overrunM, overrunL;
  logic [CW-1:0] bitCntM, bitCntL;
`ifdef PARITY_CHECK_EN
  logic          perrM, perrL;
`endif

  bit           bitsQ[$];
  logic [N-1:0] expWordM, expWordL;
  logic         expValid, expOvr, expPerr;
  int           nChecks = 0;
  int           nPassed = 0;

  sipo_deserializer #(.N(N), .MSB_FIRST(1'b1)) uMsb (
    .clk(clk), .clear(clear), .ser_in(serIn), .ser_valid(serValid),
    .word_out(wordOutM), .word_valid(wordValidM), .word_ready(wordReady),
    .overrun(overrunM),
`ifdef PARITY_CHECK_EN
    .parity_err(perrM),
`endif
    .bit_cnt(bitCntM)
  );

  sipo_deserializer #(.N(N), .MSB_FIRST(1'b0)) uLsb (
    .clk(clk), .clear(clear), .ser_in(serIn), .ser_valid(serValid),
    .word_out(wordOutL), .word_valid(wordValidL), .word_ready(wordReady),
    .overrun(overrunL),
`ifdef PARITY_CHECK_EN
    .parity_err(perrL),
`endif
    .bit_cnt(bitCntL)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: collect bits of a frame in a queue and build the word from bit order
  task automatic modelStep(input bit s, input bit v, input bit r, input bit c);
    bit           done;
    logic [N-1:0] wM, wL;
    logic         par;
    done = 1'b0;
    wM   = '0;
    wL   = '0;
    par  = 1'b0;
    if (c) begin
      bitsQ.delete();
      expWordM = '0;
      expWordL = '0;
      expValid = 1'b0;
      expOvr   = 1'b0;
      expPerr  = 1'b0;
    end else begin
      if (v) begin
        bitsQ.push_back(s);
        if (bitsQ.size() == FL) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) begin
            wM[N-1-i] = bitsQ[i];
            wL[i]     = bitsQ[i];
          end
          for (int i = 0; i < FL; i++) par = par ^ bitsQ[i];
          bitsQ.delete();
        end
      end
      if (expValid) begin
        if (done) begin
          if (r) begin
            expWordM = wM;
            expWordL = wL;
            expPerr  = par;
          end else begin
            expOvr = 1'b1;
          end
        end else if (r) begin
          expValid = 1'b0;
        end
      end else if (done) begin
        expWordM = wM;
        expWordL = wL;
        expPerr  = par;
        expValid = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare shortly after
  task automatic applyStimulus(input bit s, input bit v, input bit r, input bit c);
    serIn     = s;
    serValid  = v;
    wordReady = r;
    clear     = c;
    @(posedge clk);
    modelStep(s, v, r, c);
    #1;
    checkOutput("validM", 32'(wordValidM), 32'(expValid));
    checkOutput("validL", 32'(wordValidL), 32'(expValid));
    checkOutput("wordM",  32'(wordOutM),   32'(expWordM));
    checkOutput("wordL",  32'(wordOutL),   32'(expWordL));
    checkOutput("ovrM",   32'(overrunM),   32'(expOvr));
    checkOutput("ovrL",   32'(overrunL),   32'(expOvr));
    checkOutput("cntM",   32'(bitCntM),    32'(bitsQ.size()));
    checkOutput("cntL",   32'(bitCntL),    32'(bitsQ.size()));
`ifdef PARITY_CHECK_EN
    checkOutput("perrM",  32'(perrM),      32'(expPerr));
    checkOutput("perrL",  32'(perrL),      32'(expPerr));
`endif
  endtask

  // Send one frame first-bit = w[N-1]; rLast is the ready level on the final bit
  task automatic sendFrame(input logic [N-1:0] w, input bit r, input bit rLast,
                           input int gap, input bit p);
    bit rNow;
    for (int i = 0; i < N; i++) begin
      rNow = (i == N - 1 && FL == N) ? rLast : r;
      applyStimulus(w[N-1-i], 1'b1, rNow, 1'b0);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, r, 1'b0);
    end
`ifdef PARITY_CHECK_EN
    applyStimulus(p, 1'b1, rLast, 1'b0);
`else
    if (p) rNow = 1'b0;
`endif
  endtask

  initial begin
    // Reset held two cycles, then idle
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_word", 32'(wordOutM), 32'h0);
    checkOutput("rst_cnt",  32'(bitCntM),  32'h0);

    // Basic assembly in both bit orders with the consumer always ready
    sendFrame(8'hA5, 1'b1, 1'b1, 0, ^8'hA5);
    checkOutput("a5_wordM", 32'(wordOutM), 32'hA5);
    checkOutput("a5_wordL", 32'(wordOutL), 32'hA5);
    checkOutput("a5_valid", 32'(wordValidM), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("a5_drop", 32'(wordValidM), 32'h0);

    // Overrun: second word dropped while the consumer stalls
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'h3C, 1'b0, 1'b0, 0, ^8'h3C);
    sendFrame(8'hC3, 1'b0, 1'b0, 0, ^8'hC3);
    checkOutput("ovr_word", 32'(wordOutM), 32'h3C);
    checkOutput("ovr_flag", 32'(overrunM), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_drain", 32'(wordValidM), 32'h0);
    checkOutput("ovr_stick", 32'(overrunM), 32'h1);

    // Consume and refill in the same cycle: no overrun
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'h11, 1'b0, 1'b0, 0, ^8'h11);
    sendFrame(8'hFF, 1'b0, 1'b1, 0, ^8'hFF);
    checkOutput("swap_word", 32'(wordOutM), 32'hFF);
    checkOutput("swap_valid", 32'(wordValidM), 32'h1);
    checkOutput("swap_ovr", 32'(overrunM), 32'h0);

    // Gaps between bits, then a clear in the middle of a word
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'h5A, 1'b1, 1'b1, 3, ^8'h5A);
    checkOutput("gap_word", 32'(wordOutM), 32'h5A);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_cnt", 32'(bitCntM), 32'h0);
    sendFrame(8'h81, 1'b1, 1'b1, 0, ^8'h81);
    checkOutput("mid_word", 32'(wordOutM), 32'h81);

`ifdef PARITY_CHECK_EN
    // Parity flag with good and bad parity bits
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendFrame(8'h0F, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("par_good", 32'(perrM), 32'h0);
    sendFrame(8'h0F, 1'b0, 1'b1, 0, 1'b1);
    checkOutput("par_bad", 32'(perrM), 32'h1);
`endif

    // Random traffic with occasional clears
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom), ($urandom % 4) != 0, 1'($urandom), ($urandom % 80) == 0);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
